// File: rtl/input_state_if.sv
// Bus between the game controller / button pads and the player-input capture block.
interface input_state_if;
    logic        en_input;
    logic [31:0] seq_in_input;
    logic [3:0]  round_ctr;
    logic [3:0]  btn_in;
    logic        press_valid;
    logic [1:0]  press_colour;
    logic        complete_input;
    logic        fail_input;
    logic        busy_input;

    modport master (
        output en_input, seq_in_input, round_ctr, btn_in,
        input  press_valid, press_colour, complete_input, fail_input, busy_input
    );

    modport slave (
        input  en_input, seq_in_input, round_ctr, btn_in,
        output press_valid, press_colour, complete_input, fail_input, busy_input
    );
endinterface

// File: rtl/input_state.sv
// Player-input capture: synchronises four buttons, checks each press against the
// captured colour sequence and reports done/fail as single-cycle pulses.
module input_state #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter int unsigned TO_W           = 16
) (
    input logic          clk,
    input logic          rst_n_input,
    input_state_if.slave bus
);
    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] WAIT_PRESS   = 2'd1;
    localparam logic [1:0] WAIT_RELEASE = 2'd2;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 16'd1);

    logic [3:0]      s1_q, s2_q, s3_q;
    logic [1:0]      state_q, state_d;
    logic [3:0]      pos_q, pos_d;
    logic [31:0]     seq_q, seq_d;
    logic [3:0]      last_q, last_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            pv_q, pv_d;
    logic [1:0]      colour_q, colour_d;
    logic            cmp_q, cmp_d;
    logic            fail_q, fail_d;

    logic [3:0] rise;
    logic       press_evt;
    logic       legal;
    logic [1:0] press_c;
    logic [1:0] exp_c;

    function automatic logic [1:0] onehot_to_colour(input logic [3:0] oh);
        case (oh)
            4'b0010: onehot_to_colour = 2'd1;
            4'b0100: onehot_to_colour = 2'd2;
            4'b1000: onehot_to_colour = 2'd3;
            default: onehot_to_colour = 2'd0;
        endcase
    endfunction

    // A press is legal only when one button rose and no other button is held.
    assign rise      = s2_q & ~s3_q;
    assign press_evt = (rise != 4'd0);
    assign legal     = press_evt && ((rise & (rise - 4'd1)) == 4'd0) && (s2_q == rise);
    assign press_c   = onehot_to_colour(rise);
    assign exp_c     = seq_q[{pos_q, 1'b0} +: 2];

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        seq_d    = seq_q;
        last_d   = last_q;
        to_cnt_d = to_cnt_q;
        pv_d     = 1'b0;
        colour_d = colour_q;
        cmp_d    = 1'b0;
        fail_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en_input) begin
                    seq_d    = bus.seq_in_input;
                    last_d   = bus.round_ctr;
                    pos_d    = 4'd0;
                    to_cnt_d = '0;
                    state_d  = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                if (press_evt) begin
                    if (legal) begin
                        pv_d     = 1'b1;
                        colour_d = press_c;
                        if (press_c != exp_c) begin
                            fail_d  = 1'b1;
                            state_d = IDLE;
                        end else if (pos_q == last_q) begin
                            cmp_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            pos_d   = pos_q + 4'd1;
                            state_d = WAIT_RELEASE;
                        end
                    end else begin
                        fail_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    fail_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            WAIT_RELEASE: begin
                if (s2_q == 4'd0) begin
                    to_cnt_d = '0;
                    state_d  = WAIT_PRESS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_input) begin
        if (!rst_n_input) begin
            s1_q     <= 4'd0;
            s2_q     <= 4'd0;
            s3_q     <= 4'd0;
            state_q  <= IDLE;
            pos_q    <= 4'd0;
            seq_q    <= 32'd0;
            last_q   <= 4'd0;
            to_cnt_q <= '0;
            pv_q     <= 1'b0;
            colour_q <= 2'd0;
            cmp_q    <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            s1_q     <= bus.btn_in;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            state_q  <= state_d;
            pos_q    <= pos_d;
            seq_q    <= seq_d;
            last_q   <= last_d;
            to_cnt_q <= to_cnt_d;
            pv_q     <= pv_d;
            colour_q <= colour_d;
            cmp_q    <= cmp_d;
            fail_q   <= fail_d;
        end
    end

    assign bus.press_valid    = pv_q;
    assign bus.press_colour   = colour_q;
    assign bus.complete_input = cmp_q;
    assign bus.fail_input     = fail_q;
    assign bus.busy_input     = (state_q != IDLE);
endmodule
